// File: rtl/n64_i2s_tx.sv
// n64_i2s_tx: I2S transmitter. It serializes one parallel stereo PCM pair per
// frame onto ASCLK/ALRCLK/ASDATA. A single-entry hold buffer with a
// valid/ready handshake sits between the sample producer and frame timing.
//
// Ports:
//   AMCLK_i        audio master clock, the only clock
//   nARST          asynchronous active-low reset
//   PDATA_LEFT_i   left sample, two's complement
//   PDATA_RIGHT_i  right sample
//   PDATA_VALID_i  sample pair valid
//   PDATA_READY_o  hold buffer empty; the pair is accepted on VALID & READY
//   ASCLK_o        serial bit clock (AMCLK / (2*SCLK_HALF_DIV))
//   ALRCLK_o       word select, 0 = left, 1 = right
//   ASDATA_o       serial data, MSB first
//   UNDERRUN_o     one-cycle pulse at a frame start with no buffered pair
//
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing
// (MSB coincident with the ALRCLK edge). The default is standard I2S, where
// the MSB follows the ALRCLK edge by one bit.
module n64_i2s_tx #(
  parameter int unsigned SCLK_HALF_DIV = 2,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned DATA_WIDTH    = 16
) (
  input  logic                  AMCLK_i,
  input  logic                  nARST,
  input  logic [DATA_WIDTH-1:0] PDATA_LEFT_i,
  input  logic [DATA_WIDTH-1:0] PDATA_RIGHT_i,
  input  logic                  PDATA_VALID_i,
  output logic                  PDATA_READY_o,
  output logic                  ASCLK_o,
  output logic                  ALRCLK_o,
  output logic                  ASDATA_o,
  output logic                  UNDERRUN_o
);

  localparam int unsigned DIV_W      = (SCLK_HALF_DIV > 1) ? $clog2(SCLK_HALF_DIV) : 1;
  localparam int unsigned BIT_W      = $clog2(2 * SLOT_BITS);
  localparam int unsigned IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned FRAME_LAST = 2 * SLOT_BITS - 1;

  logic [DIV_W-1:0]      divcnt_q, divcnt_d;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  sclk_q, sclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic                  hold_empty_q, hold_empty_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [DATA_WIDTH-1:0] act_l_q, act_l_d;
  logic [DATA_WIDTH-1:0] act_r_q, act_r_d;

  logic                  div_term;
  logic                  fall;
  logic                  accept;
  logic [BIT_W-1:0]      bit_next;
  logic [BIT_W-1:0]      slot_b;
  logic [DATA_WIDTH-1:0] sample;
  logic [IDX_W-1:0]      idx;

  // Next-state logic: divider, handshake, and serial state on ASCLK falls.
  always_comb begin
    divcnt_d     = divcnt_q;
    bitcnt_d     = bitcnt_q;
    sclk_d       = sclk_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    underrun_d   = 1'b0;
    hold_empty_d = hold_empty_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    act_l_d      = act_l_q;
    act_r_d      = act_r_q;
    bit_next     = '0;
    slot_b       = '0;
    sample       = '0;
    idx          = '0;

    div_term = (divcnt_q == DIV_W'(SCLK_HALF_DIV - 1));
    fall     = div_term & sclk_q;
    accept   = PDATA_VALID_i & hold_empty_q;

    if (div_term) begin
      divcnt_d = '0;
      sclk_d   = ~sclk_q;
    end else begin
      divcnt_d = divcnt_q + DIV_W'(1);
    end

    if (accept) begin
      hold_l_d     = PDATA_LEFT_i;
      hold_r_d     = PDATA_RIGHT_i;
      hold_empty_d = 1'b0;
    end

    if (fall) begin
      bit_next = (bitcnt_q == BIT_W'(FRAME_LAST)) ? '0 : bitcnt_q + BIT_W'(1);
      bitcnt_d = bit_next;

      // Frame boundary: swap in the held pair, or send silence. An accept in
      // this same cycle has not reached hold yet, so it still counts as underrun.
      if (bit_next == '0) begin
        if (!hold_empty_q) begin
          act_l_d      = hold_l_q;
          act_r_d      = hold_r_q;
          hold_empty_d = 1'b1;
        end else begin
          act_l_d    = '0;
          act_r_d    = '0;
          underrun_d = 1'b1;
        end
      end

      lrclk_d = (bit_next >= BIT_W'(SLOT_BITS));
      slot_b  = lrclk_d ? (bit_next - BIT_W'(SLOT_BITS)) : bit_next;
      sample  = lrclk_d ? act_r_d : act_l_d;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      if (32'(slot_b) < DATA_WIDTH) begin
        idx     = IDX_W'(DATA_WIDTH - 32'd1 - 32'(slot_b));
        sdata_d = sample[idx];
      end else begin
        sdata_d = 1'b0;
      end
`else
      if ((slot_b != '0) && (32'(slot_b) <= DATA_WIDTH)) begin
        idx     = IDX_W'(DATA_WIDTH - 32'(slot_b));
        sdata_d = sample[idx];
      end else begin
        sdata_d = 1'b0;
      end
`endif
    end
  end

  // State register.
  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      divcnt_q     <= '0;
      bitcnt_q     <= BIT_W'(FRAME_LAST);
      sclk_q       <= 1'b0;
      lrclk_q      <= 1'b1;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
      hold_empty_q <= 1'b1;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      act_l_q      <= '0;
      act_r_q      <= '0;
    end else begin
      divcnt_q     <= divcnt_d;
      bitcnt_q     <= bitcnt_d;
      sclk_q       <= sclk_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      underrun_q   <= underrun_d;
      hold_empty_q <= hold_empty_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      act_l_q      <= act_l_d;
      act_r_q      <= act_r_d;
    end
  end

  assign PDATA_READY_o = hold_empty_q;
  assign ASCLK_o       = sclk_q;
  assign ALRCLK_o      = lrclk_q;
  assign ASDATA_o      = sdata_q;
  assign UNDERRUN_o    = underrun_q;

endmodule

// File: tb/tb_n64_i2s_tx.sv
// Directed bench for n64_i2s_tx at default parameters.
module tb_n64_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] pl;
  logic [15:0] pr;
  logic        valid;
  logic        ready;
  logic        sclk;
  logic        alr;
  logic        sd;
  logic        uf;

  int n_cmp;
  int n_err;
  int n_und;
  int n_acc;
  int n_one;
  bit prod_en;

  logic [63:0] d;
  logic [63:0] lrs;

  n64_i2s_tx dut (
    .AMCLK_i       (clk),
    .nARST         (rst_n),
    .PDATA_LEFT_i  (pl),
    .PDATA_RIGHT_i (pr),
    .PDATA_VALID_i (valid),
    .PDATA_READY_o (ready),
    .ASCLK_o       (sclk),
    .ALRCLK_o      (alr),
    .ASDATA_o      (sd),
    .UNDERRUN_o    (uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 32-bit slot image, b=0 in the MSB position.
  function automatic logic [31:0] exp_slot(input logic [15:0] s);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return {s, 16'h0000};
`else
    return {1'b0, s, 15'h0000};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one AMCLK cycle; sampling happens on the falling edge.
  task automatic step();
    logic acc;
    acc = prod_en && valid && ready;
    @(negedge clk);
    if (acc) begin
      n_acc++;
      pl = pl + 16'd1;
      pr = pr - 16'd1;
    end
    if (uf) n_und++;
    if (sd) n_one++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_und = 0;
    n_acc = 0;
    n_one = 0;
  endtask

  // Step until ALRCLK falls (frame start).
  task automatic sync_frame();
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = alr;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (prev && !alr) found = 1'b1;
      prev = alr;
    end
    chk("sync_frame", 64'(found), 64'd1);
  endtask

  // Record ASDATA/ALRCLK at the next n ASCLK rising edges, first bit at bit 63.
  task automatic run_risings(input int n, output logic [63:0] dat, output logic [63:0] lr);
    logic prev;
    int   cnt;
    dat  = '0;
    lr   = '0;
    cnt  = 0;
    prev = sclk;
    for (int i = 0; i < 1000 && cnt < n; i++) begin
      step();
      if (!prev && sclk) begin
        if (cnt < 64) begin
          dat[63-cnt] = sd;
          lr[63-cnt]  = alr;
        end
        cnt++;
      end
      prev = sclk;
    end
    chk("rising_count", 64'(cnt), 64'(n));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    n_und   = 0;
    n_acc   = 0;
    n_one   = 0;
    prod_en = 1'b0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    pl      = '0;
    pr      = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_lr", 64'(alr), 64'd1);
    chk("rst_sd", 64'(sd), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_uf", 64'(uf), 64'd0);

    // Idle after reset: divider timing and periodic underrun
    rst_n = 1'b1;
    step(); step();
    chk("idle_sclk_hi", 64'(sclk), 64'd1);
    step(); step();
    chk("idle_sclk_lo", 64'(sclk), 64'd0);
    chk("idle_lr0", 64'(alr), 64'd0);
    chk("idle_uf_first", 64'(uf), 64'd1);
    chk("idle_sd", 64'(sd), 64'd0);
    step();
    chk("idle_uf_one_cycle", 64'(uf), 64'd0);
    repeat (254) step();
    chk("idle_uf_gap", 64'(uf), 64'd0);
    step();
    chk("idle_uf_repeat", 64'(uf), 64'd1);
    chk("idle_uf_count", 64'(n_und), 64'd2);
    chk("idle_sd_ones", 64'(n_one), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);

    // Single pair accepted before the first boundary
    do_reset();
    valid = 1'b1;
    pl    = 16'h8001;
    pr    = 16'h7FFE;
    step();
    chk("one_ready_lo", 64'(ready), 64'd0);
    valid = 1'b0;
    pl    = 16'hDEAD;
    pr    = 16'hBEEF;
    step(); step();
    chk("one_ready_still_lo", 64'(ready), 64'd0);
    step();
    chk("one_ready_back", 64'(ready), 64'd1);
    chk("one_no_uf", 64'(uf), 64'd0);
    chk("one_lr0", 64'(alr), 64'd0);
    run_risings(64, d, lrs);
    chk("one_left", 64'(d[63:32]), 64'(exp_slot(16'h8001)));
    chk("one_right", 64'(d[31:0]), 64'(exp_slot(16'h7FFE)));
    chk("one_lrclk", lrs, 64'h00000000_FFFFFFFF);

    // Continuous stream
    do_reset();
    pl      = 16'h1000;
    pr      = 16'hF000;
    valid   = 1'b1;
    prod_en = 1'b1;
    sync_frame();
    run_risings(64, d, lrs);
    chk("strm0_left", 64'(d[63:32]), 64'(exp_slot(16'h1000)));
    chk("strm0_right", 64'(d[31:0]), 64'(exp_slot(16'hF000)));
    sync_frame();
    run_risings(64, d, lrs);
    chk("strm1_left", 64'(d[63:32]), 64'(exp_slot(16'h1001)));
    chk("strm1_right", 64'(d[31:0]), 64'(exp_slot(16'hEFFF)));
    sync_frame();
    run_risings(64, d, lrs);
    chk("strm2_left", 64'(d[63:32]), 64'(exp_slot(16'h1002)));
    chk("strm2_right", 64'(d[31:0]), 64'(exp_slot(16'hEFFE)));
    prod_en = 1'b0;
    valid   = 1'b0;
    chk("strm_no_uf", 64'(n_und), 64'd0);
    chk("strm_accepts", 64'(n_acc), 64'd4);

    // Accept coincident with an empty-hold boundary
    do_reset();
    step(); step(); step();
    valid = 1'b1;
    pl    = 16'h1234;
    pr    = 16'hC3C3;
    step();
    valid = 1'b0;
    chk("coin_uf", 64'(uf), 64'd1);
    chk("coin_ready_lo", 64'(ready), 64'd0);
    chk("coin_lr0", 64'(alr), 64'd0);
    run_risings(64, d, lrs);
    chk("coin_silent", d, 64'd0);
    sync_frame();
    chk("coin_next_no_uf", 64'(uf), 64'd0);
    run_risings(64, d, lrs);
    chk("coin_next_left", 64'(d[63:32]), 64'(exp_slot(16'h1234)));
    chk("coin_next_right", 64'(d[31:0]), 64'(exp_slot(16'hC3C3)));

    // Reset in the middle of the right slot
    do_reset();
    valid = 1'b1;
    pl    = 16'h0000;
    pr    = 16'hFFFF;
    step();
    valid = 1'b0;
    sync_frame();
    valid = 1'b1;
    pl    = 16'h5555;
    pr    = 16'h5555;
    step();
    valid = 1'b0;
    run_risings(43, d, lrs);
    chk("mid_pre_sd", 64'(sd), 64'd1);
    chk("mid_pre_lr", 64'(alr), 64'd1);
    chk("mid_pre_sclk", 64'(sclk), 64'd1);
    chk("mid_pre_ready", 64'(ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", 64'(sclk), 64'd0);
    chk("mid_rst_lr", 64'(alr), 64'd1);
    chk("mid_rst_sd", 64'(sd), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_uf", 64'(uf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    chk("mid_restart_sclk", 64'(sclk), 64'd1);
    step(); step();
    chk("mid_restart_uf", 64'(uf), 64'd1);
    chk("mid_restart_lr0", 64'(alr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
